// File: rtl/spike_decoder_pkg.sv
// Shared constants and state encoding for the spike rate decoder.
package spike_decoder_pkg;

    localparam int NUM_NEURONS_DEF = 3;
    localparam int CNT_W_DEF       = 8;
    localparam int WIN_W_DEF       = 8;
    localparam int WINNER_W        = $clog2(NUM_NEURONS_DEF);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Spike input / result output bundle between the spiking network, the decoder and its reader.
interface spike_rate_decoder_if
    import spike_decoder_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF
) ();

    logic                         enable;
    logic [WIN_W-1:0]             window_len;
    logic [NUM_NEURONS-1:0]       spikes_in;
    logic [NUM_NEURONS*CNT_W-1:0] counts_out;
    logic [WINNER_W-1:0]          winner;
    logic                         no_spike;
    logic                         result_valid;
    logic                         busy;

    modport master (
        output enable, window_len, spikes_in,
        input  counts_out, winner, no_spike, result_valid, busy
    );

    modport slave (
        input  enable, window_len, spikes_in,
        output counts_out, winner, no_spike, result_valid, busy
    );

endinterface

// File: rtl/spike_argmax.sv
// Combinational argmax over packed counters; ties resolve to the lowest index.
module spike_argmax #(
    parameter int NUM_NEURONS = 3,
    parameter int CNT_W       = 8,
    parameter int WINNER_W    = 2
) (
    input  logic [NUM_NEURONS*CNT_W-1:0] counts,
    output logic [WINNER_W-1:0]          index,
    output logic                         all_zero
);

    logic [CNT_W-1:0] best;

    always_comb begin
        index    = '0;
        all_zero = 1'b1;
        best     = counts[0 +: CNT_W];
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (counts[k*CNT_W +: CNT_W] != '0) begin
                all_zero = 1'b0;
            end
            // Strict compare keeps the earlier neuron on a tie.
            if (counts[k*CNT_W +: CNT_W] > best) begin
                best  = counts[k*CNT_W +: CNT_W];
                index = WINNER_W'(k);
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per neuron over a programmable window and publishes
// saturated counts, the winning neuron and a result strobe at each window end.
module spike_rate_decoder
    import spike_decoder_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    spike_rate_decoder_if.slave bus
);

    state_t                       state_reg, state_next;
    logic [NUM_NEURONS*CNT_W-1:0] acc_reg;
    logic [NUM_NEURONS*CNT_W-1:0] acc_next;
    logic [NUM_NEURONS*CNT_W-1:0] counts_reg;
    logic [WIN_W-1:0]             win_cnt_reg;
    logic [WIN_W-1:0]             len_reg;
    logic [WINNER_W-1:0]          winner_reg;
    logic                         no_spike_reg;
    logic                         result_valid_reg;

    logic [WIN_W-1:0]             cur_len;
    logic [WIN_W-1:0]             cur_cnt;
    logic                         last_sample;
    logic                         sampling;
    logic                         window_done;
    logic [WINNER_W-1:0]          argmax_index;
    logic                         argmax_zero;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_acc
            logic [CNT_W-1:0] acc_k;
            assign acc_k = acc_reg[gi*CNT_W +: CNT_W];
            assign acc_next[gi*CNT_W +: CNT_W] =
                (bus.spikes_in[gi] && (acc_k != {CNT_W{1'b1}})) ? acc_k + CNT_W'(1) : acc_k;
        end
    endgenerate

    spike_argmax #(
        .NUM_NEURONS (NUM_NEURONS),
        .CNT_W       (CNT_W),
        .WINNER_W    (WINNER_W)
    ) u_argmax (
        .counts   (acc_next),
        .index    (argmax_index),
        .all_zero (argmax_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The start cycle in IDLE is already sample 0, so it sees a counter of 0
    // and the length presented on the port.
    always_comb begin
        state_next  = state_reg;
        sampling    = 1'b0;
        window_done = 1'b0;
        cur_len     = (state_reg == IDLE) ? bus.window_len : len_reg;
        cur_cnt     = (state_reg == IDLE) ? '0 : win_cnt_reg;
        last_sample = (cur_cnt == (cur_len - WIN_W'(1)));
        case (state_reg)
            IDLE: begin
                if (bus.enable) begin
                    sampling    = 1'b1;
                    window_done = last_sample;
                    state_next  = COUNT;
                end
            end
            COUNT: begin
                if (last_sample) begin
                    sampling    = 1'b1;
                    window_done = 1'b1;
                    state_next  = bus.enable ? COUNT : IDLE;
                end else if (!bus.enable) begin
                    state_next = IDLE;
                end else begin
                    sampling = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_reg          <= '0;
            win_cnt_reg      <= '0;
            len_reg          <= '0;
            counts_reg       <= '0;
            winner_reg       <= '0;
            no_spike_reg     <= 1'b1;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= window_done;
            if (window_done) begin
                counts_reg   <= acc_next;
                winner_reg   <= argmax_index;
                no_spike_reg <= argmax_zero;
                acc_reg      <= '0;
                win_cnt_reg  <= '0;
                len_reg      <= bus.window_len;
            end else if (sampling) begin
                acc_reg     <= acc_next;
                win_cnt_reg <= cur_cnt + WIN_W'(1);
                if (state_reg == IDLE) begin
                    len_reg <= bus.window_len;
                end
            end else begin
                // Idle or aborted window: partial counts are discarded.
                acc_reg     <= '0;
                win_cnt_reg <= '0;
            end
        end
    end

    assign bus.counts_out   = counts_reg;
    assign bus.winner       = winner_reg;
    assign bus.no_spike     = no_spike_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.busy         = (state_reg == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed and randomized bench for spike_rate_decoder against a window-list reference model.
module tb_spike_rate_decoder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    spike_rate_decoder_if bus ();

    spike_rate_decoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // Reference model: a window is a list of sampled spike vectors.
    bit         m_active;
    int         m_len;
    logic [2:0] m_samples[$];
    int         exp_cnt[3];
    int         exp_winner;
    bit         exp_no_spike;
    bit         exp_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_counts_vec();
        return {8'(exp_cnt[2]), 8'(exp_cnt[1]), 8'(exp_cnt[0])};
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_len    = 0;
        m_samples.delete();
        for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
        exp_winner   = 0;
        exp_no_spike = 1'b1;
        exp_valid    = 1'b0;
    endtask

    task automatic publish();
        int best;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = 0;
            foreach (m_samples[s]) if (m_samples[s][k]) c++;
            exp_cnt[k] = (c > 255) ? 255 : c;
        end
        best       = exp_cnt[0];
        exp_winner = 0;
        for (int k = 1; k < 3; k++) begin
            if (exp_cnt[k] > best) begin
                best       = exp_cnt[k];
                exp_winner = k;
            end
        end
        exp_no_spike = (exp_cnt[0] == 0) && (exp_cnt[1] == 0) && (exp_cnt[2] == 0);
    endtask

    task automatic model_edge(input bit en, input int len, input logic [2:0] sp);
        int eff;
        exp_valid = 1'b0;
        eff = (len == 0) ? 256 : len;
        if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_len    = eff;
                m_samples.delete();
            end
        end else if (!en && (m_samples.size() != m_len - 1)) begin
            m_active = 1'b0;
            m_samples.delete();
        end
        if (m_active) begin
            m_samples.push_back(sp);
            if (m_samples.size() == m_len) begin
                publish();
                exp_valid = 1'b1;
                m_samples.delete();
                if (en) m_len = eff;
                else    m_active = 1'b0;
            end
        end
    endtask

    task automatic tick(input bit en, input logic [7:0] len, input logic [2:0] sp);
        bus.enable     = en;
        bus.window_len = len;
        bus.spikes_in  = sp;
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge(en, int'(len), sp);
        #1;
        check("result_valid", 32'(bus.result_valid), 32'(exp_valid));
        check("busy",         32'(bus.busy),         32'(m_active));
        check("counts_out",   32'(bus.counts_out),   32'(exp_counts_vec()));
        check("winner",       32'(bus.winner),       32'(exp_winner));
        check("no_spike",     32'(bus.no_spike),     32'(exp_no_spike));
        if (bus.result_valid === 1'b1) pulses++;
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.window_len = '0;
        bus.spikes_in  = '0;
        model_reset();

        reset_n = 1'b0;
        tick(0, 0, 3'b000);
        tick(0, 0, 3'b000);
        reset_n = 1'b1;

        // Reset in the middle of a window
        for (int i = 0; i < 5; i++) tick(1, 10, 3'b111);
        reset_n = 1'b0;
        tick(0, 10, 3'b111);
        reset_n = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) tick(0, 10, 3'b111);
        check("rst_pulses", 32'(pulses), 32'd0);
        check("rst_counts", 32'(bus.counts_out), 32'd0);
        check("rst_no_spike", 32'(bus.no_spike), 32'd1);

        // Basic 4-cycle window, last sample with enable already low
        pulses = 0;
        tick(1, 4, 3'b010);
        tick(1, 4, 3'b010);
        tick(1, 4, 3'b010);
        tick(0, 4, 3'b001);
        check("basic_strobe", 32'(bus.result_valid), 32'd1);
        tick(0, 4, 3'b000);
        tick(0, 4, 3'b000);
        check("basic_pulses", 32'(pulses), 32'd1);
        check("basic_counts", 32'(bus.counts_out), 32'h000301);
        check("basic_winner", 32'(bus.winner), 32'd1);
        check("basic_no_spike", 32'(bus.no_spike), 32'd0);

        // 256-cycle window with saturation of neuron 0
        pulses = 0;
        for (int i = 0; i < 255; i++) tick(1, 0, 3'b001);
        check("sat_no_early", 32'(pulses), 32'd0);
        tick(0, 0, 3'b001);
        tick(0, 0, 3'b000);
        check("sat_pulses", 32'(pulses), 32'd1);
        check("sat_counts", 32'(bus.counts_out), 32'h0000FF);
        check("sat_winner", 32'(bus.winner), 32'd0);

        // Tie between neurons 1 and 2, then an empty window
        tick(1, 6, 3'b110);
        tick(1, 6, 3'b110);
        for (int i = 0; i < 4; i++) tick(1, 6, 3'b000);
        check("tie_counts", 32'(bus.counts_out), 32'h020200);
        check("tie_winner", 32'(bus.winner), 32'd1);
        for (int i = 0; i < 5; i++) tick(1, 6, 3'b000);
        tick(0, 6, 3'b000);
        check("empty_counts", 32'(bus.counts_out), 32'd0);
        check("empty_winner", 32'(bus.winner), 32'd0);
        check("empty_no_spike", 32'(bus.no_spike), 32'd1);

        // Back-to-back windows, length change mid-window
        pulses = 0;
        for (int i = 0; i < 9; i++) tick(1, 3, 3'($urandom_range(0, 7)));
        check("b2b_pulses", 32'(pulses), 32'd3);
        pulses = 0;
        tick(1, 3, 3'($urandom_range(0, 7)));
        tick(1, 5, 3'($urandom_range(0, 7)));
        tick(1, 5, 3'($urandom_range(0, 7)));
        check("b2b_len_held", 32'(pulses), 32'd1);
        for (int i = 0; i < 4; i++) tick(1, 5, 3'($urandom_range(0, 7)));
        check("b2b_len_new_wait", 32'(pulses), 32'd1);
        tick(1, 5, 3'($urandom_range(0, 7)));
        check("b2b_len_new", 32'(pulses), 32'd2);
        tick(0, 5, 3'b000);

        // Known short window, then an aborted one
        tick(1, 2, 3'b100);
        tick(0, 2, 3'b100);
        tick(0, 2, 3'b000);
        pulses = 0;
        for (int i = 0; i < 5; i++) tick(1, 8, 3'b111);
        tick(0, 8, 3'b111);
        check("abort_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) tick(0, 8, 3'b000);
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_counts", 32'(bus.counts_out), 32'h020000);
        check("abort_winner", 32'(bus.winner), 32'd2);

        // Randomized traffic with occasional resets and aborts
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            tick($urandom_range(0, 15) != 0,
                 ($urandom_range(0, 49) == 0) ? 8'd0 : 8'($urandom_range(1, 9)),
                 3'($urandom_range(0, 7)));
        end
        reset_n = 1'b1;
        tick(0, 0, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Downstream stage of the spiking neuron network; consumes its 3-bit second-layer spike vector.
- Counts spikes per output neuron over a programmable observation window.
- At each window end, publishes saturated per-neuron counts, the winning neuron index and a one-cycle result strobe for the chip output or host readout.

Parameters:
- NUM_NEURONS, 3, number of spike lines observed.
- CNT_W, 8, width of each per-neuron spike counter (saturating).
- WIN_W, 8, width of the window-length input.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- enable  input  1  run decoding; low aborts the current window.
- window_len  input  WIN_W  window length in cycles; 0 means 2^WIN_W (256 cycles).
- spikes_in  input  NUM_NEURONS  spike vector from the network, one bit per neuron.
- counts_out  output  NUM_NEURONS*CNT_W  last window counts; neuron k occupies bits [k*CNT_W +: CNT_W].
- winner  output  2  index of the neuron with the highest count in the last window.
- no_spike  output  1  high when every count in the last window was 0.
- result_valid  output  1  one-cycle pulse when counts_out, winner and no_spike update.
- busy  output  1  high while a window is in progress.

Behaviour:
- Reset (reset_n low at a clk edge) takes priority over everything:
  - state to IDLE;
  - accumulators, window counter, counts_out and winner cleared to 0;
  - no_spike set to 1;
  - result_valid and busy set to 0.
- States:
  - IDLE: busy=0, accumulators held at 0. On enable=1, go to COUNT, latch window_len into len_q, clear the window counter, and sample spikes_in in that same cycle.
  - COUNT: busy=1. Each cycle, every accumulator k with spikes_in[k]=1 increments by 1, saturating at 2^CNT_W-1 (255 stays 255).
- Window end:
  - The last sample cycle is the one where the window counter equals len_q-1 (255 when len_q=0).
  - On that edge, counts_out takes the final counts, including the last cycle's spikes.
  - winner and no_spike update on the same edge; result_valid is 1 for the following cycle only.
  - Accumulators and the window counter are cleared on the same edge.
- Back-to-back windows:
  - If enable is still 1 at window end, stay in COUNT.
  - window_len is re-latched and the next cycle is sample 0 of the new window, so there are no dead cycles between windows.
  - If enable is 0 at window end, go to IDLE.
- Abort: enable=0 during COUNT before the last sample cycle.
  - Go to IDLE next cycle and discard the partial counts (accumulators cleared).
  - No result_valid; counts_out, winner and no_spike keep their previous values.
- Mid-window changes: a window_len change while in COUNT has no effect until the next window start.
- Winner selection:
  - winner is the argmax over the final counts.
  - Ties go to the lowest index.
  - If all counts are 0, winner=0 and no_spike=1; otherwise no_spike=0.
- Latency: spikes sampled in window cycle N are visible on counts_out len-N cycles later, coincident with result_valid.
- Outputs hold their values between result_valid pulses.

Decomposition:
- Package spike_decoder_pkg holds:
  - the NUM_NEURONS, CNT_W and WIN_W defaults;
  - the state enum {IDLE, COUNT};
  - the WINNER_W constant, $clog2(NUM_NEURONS).
- One sub-module, spike_argmax: purely combinational, takes NUM_NEURONS counts and produces the index plus an all-zero flag, with lowest-index tie-break. It is instantiated once, and its outputs are registered in the top module at window end.

Test Plan:
- Reset mid-window: enable=1, window_len=10, spikes_in=3'b111 for 5 cycles, then reset_n=0 for 1 cycle. Expected: counts_out=0, no_spike=1, busy=0, no result_valid afterwards until re-enabled.
- Basic window: window_len=4, neuron 1 spikes on 3 cycles, neuron 0 on 1 cycle. Expected: one result_valid pulse 4 cycles after enable, counts {n2:0, n1:3, n0:1}, winner=1, no_spike=0.
- Saturation and len=0: window_len=0, spikes_in=3'b001 constantly. Expected: result_valid after 256 cycles, count0=255, winner=0.
- Tie and empty cases, each in a window_len=6 window:
  - neurons 1 and 2 each spike 2 times: winner=1;
  - next window with no spikes: winner=0, no_spike=1, counts all 0.
- Back-to-back windows: enable held high, window_len=3. Expected: result_valid every 3 cycles with no gap; a window_len change to 5 mid-window takes effect only from the next window.
- Abort: window_len=8, enable dropped at cycle 5. Expected: no result_valid, outputs keep the previous window's values, busy=0 on the next cycle.
